// File: rtl/mem_arb_pkg.sv
// Shared types and default line geometry for the memory-channel arbiter.
// The caches use the same address and data widths.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection: fixed mode picks the lowest requesting index,
// round-robin mode picks the first requester after ptr, wrapping around.
module mem_arb_picker #(
  parameter int N_CH  = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_mode,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_WIDE = (IDX_W+1)'(N_CH);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk the search order backwards so the earliest candidate is the last
  // one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (rr_mode) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= N_WIDE) begin
          sum = sum - N_WIDE;
        end
        cand = sum[IDX_W-1:0];
      end else begin
        cand = IDX_W'(k - 1);
      end
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// N-channel arbiter sharing one line-wide memory port between cache controllers,
// with run-time fixed or round-robin priority and a registered memory request.
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rr_mode,
  input  logic [N_CH-1:0]          ch_read,
  input  logic [N_CH-1:0]          ch_write,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Handshake: a channel holds ch_read/ch_write (plus addr/wdata) until it sees
  // its ch_ready pulse; the memory side sees mem_read/mem_write held steady until
  // the single-cycle mem_ready, which completes the transfer in that same cycle.

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [N_CH-1:0]    req;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  addr_a  [N_CH];
  logic [DATA_W-1:0]  wdata_a [N_CH];

  assign req = ch_read | ch_write;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign addr_a[i]  = ch_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = ch_wdata[i*DATA_W +: DATA_W];
  end

  mem_arb_picker #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .rr_mode (rr_mode),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          mem_addr_d  = addr_a[pick_idx];
          mem_wdata_d = wdata_a[pick_idx];
          // Write wins when a channel raises both strobes.
          mem_write_d = ch_write[pick_idx];
          mem_read_d  = ch_read[pick_idx] & ~ch_write[pick_idx];
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          ptr_d       = grant_q;
          state_d     = ST_DRAIN;
        end
      end
      // One dead cycle lets the finished channel withdraw its request.
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= IDX_W'(N_CH - 1);
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    ch_ready = '0;
    if (state_q == ST_BUSY && mem_ready) begin
      ch_ready[grant_q] = 1'b1;
    end
  end

  assign ch_rdata  = mem_rdata;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Parametrised N-channel arbiter that lets several cache controllers share one slow-memory port.
- Example users: Icache, Dcache, and a later L2 or prefetch unit.
- Sits between the cache memory-side interfaces and a single 128-bit-line memory port, using the same read/write/addr/wdata/rdata/ready protocol the caches already use.
- Adds two things the current dedicated-port top does not have:
  - run-time selectable fixed or round-robin priority;
  - a registered, stable memory-side request.

Parameters:
- N_CH, 2, number of requesting channels (2..8); channel 0 is the Icache side by convention.
- ADDR_W, 28, line-address width (byte address bits 31:4).
- DATA_W, 128, line width in bits.
- IDX_W, $clog2(N_CH) (min 1), grant index width (derived, not overridden).

Ports:
- clk in 1 system clock
- rst_n in 1 asynchronous active-low reset
- rr_mode in 1 1 = round-robin, 0 = fixed priority (lowest index wins); sampled only in IDLE
- ch_read in N_CH per-channel line-read request, held until that channel's ch_ready
- ch_write in N_CH per-channel line-write request, held until ch_ready
- ch_addr in N_CH*ADDR_W packed line addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata in N_CH*DATA_W packed write lines
- ch_rdata out DATA_W read line, broadcast to all channels (valid only with ch_ready)
- ch_ready out N_CH one-hot completion pulse to the granted channel
- mem_read out 1 memory read request
- mem_write out 1 memory write request
- mem_addr out ADDR_W memory line address
- mem_wdata out DATA_W memory write line
- mem_rdata in DATA_W memory read line
- mem_ready in 1 memory completion pulse
- busy out 1 high while a transaction is granted (BUSY or DRAIN)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - ch_ready=0, busy=0, grant=0, rr pointer=N_CH-1 (so channel 0 wins first).
  - Reset mid-transaction abandons it; no ch_ready is issued.
- Requests: req[i] = ch_read[i] | ch_write[i].
  - If both are set on one channel, the write is forwarded and the read is ignored for that grant.
- FSM, three states:
  - IDLE:
    - If any req, pick winner g:
      - fixed mode: lowest index with req set;
      - rr mode: first index with req set searching from ptr+1 upward, wrapping mod N_CH.
    - Register grant=g and mem_addr/mem_wdata from channel g.
    - Set mem_write=ch_write[g] and mem_read=ch_read[g]&~ch_write[g].
    - Go to BUSY.
    - Request visible at cycle t appears on mem_* at cycle t+1.
  - BUSY:
    - mem_* are held from the registers; channel inputs are not re-sampled.
    - On mem_ready=1:
      - ch_ready[grant]=1 combinationally in the same cycle;
      - ch_rdata=mem_rdata (pass-through, always driven);
      - mem_read/mem_write cleared at the next edge;
      - ptr<=grant;
      - go to DRAIN.
  - DRAIN:
    - One cycle with no memory request, so the completing channel's stale request cannot be re-granted.
    - Then go to IDLE.
- Back-to-back throughput: ready at cycle t, next grant registered at the t+2 edge, next mem request visible at t+3.
- ch_ready is zero outside BUSY. mem_ready in IDLE/DRAIN is ignored.
- A channel dropping its request while granted is a protocol violation. The transaction still completes and ready still pulses to that channel.
- rr_mode changes take effect at the next IDLE arbitration only.
- No starvation in rr mode: with all channels requesting continuously, grants cycle 0,1,..,N_CH-1.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DRAIN};
  - default ADDR_W/DATA_W constants shared with the caches.
- Sub-module mem_arb_picker holds the combinational winner selection: inputs req vector, ptr, rr_mode; outputs found, idx.
- The top module holds the FSM, registers and muxing.

Test Plan:
- Single read: ch_read=2'b01, ch_addr[0]=28'h0000040, memory returns 128'hA5..A5 after 4 cycles -> mem_read=1 at t+1 with mem_addr=28'h0000040; ch_ready=2'b01 for exactly one cycle with ch_rdata=128'hA5..A5; mem_read=0 the following cycle.
- Write priority in one channel: ch_read[1]=ch_write[1]=1, ch_wdata[1]=128'h1234 -> mem_write=1, mem_read=0, mem_wdata=128'h1234.
- Fixed priority: rr_mode=0, both channels requesting continuously for 3 transactions -> all 3 grants go to channel 0; channel 1 granted only after ch_read[0] drops.
- Round-robin: rr_mode=1, N_CH=4, all four requesting -> grant order 0,1,2,3,0; gap of exactly 2 cycles between ch_ready and the next mem_read rising.
- Reset mid-operation: assert rst_n=0 while in BUSY with mem_ready pending -> all outputs 0 immediately; after release, ch_ready stays 0 until a new request completes; first rr grant goes to channel 0.
- Spurious ready: mem_ready=1 in IDLE and in DRAIN -> ch_ready stays 0 and state is unchanged.
